// File: rtl/bus_memory_if.sv
// Processor bus control and program-loader handshake for bus_memory.
// The shared data bus stays a plain inout so the tristate net resolves at the top.
interface bus_memory_if #(
   parameter int unsigned AW = 8,
   parameter int unsigned DW = 8
);
   logic [AW-1:0] add;
   logic          rd;
   logic          wrt;
   logic          ld_start;
   logic [AW-1:0] ld_base;
   logic          ld_valid;
   logic [DW-1:0] ld_data;
   logic          ld_last;
   logic          ld_ready;
   logic          cpu_hold;
   logic          ld_done;
   logic [AW:0]   ld_count;
   logic          bus_err;

   modport master (
      output add, rd, wrt, ld_start, ld_base, ld_valid, ld_data, ld_last,
      input  ld_ready, cpu_hold, ld_done, ld_count, bus_err
   );

   modport slave (
      input  add, rd, wrt, ld_start, ld_base, ld_valid, ld_data, ld_last,
      output ld_ready, cpu_hold, ld_done, ld_count, bus_err
   );
endinterface

// File: rtl/bus_memory.sv
// Byte memory shared between a processor bus (zero-latency read, write per
// strobed cycle) and a streaming program loader that holds the processor off.
module bus_memory #(
   parameter int unsigned AW = 8,
   parameter int unsigned DW = 8
) (
   input  logic           clk,
   input  logic           rst,
   bus_memory_if.slave    bus,
   inout  wire [DW-1:0]   dat
);

   localparam int unsigned Depth    = 2 ** AW;
   localparam logic [AW:0] CountMax = Depth[AW:0];
   localparam logic [AW:0] CountOne = 1;
   localparam logic [AW-1:0] PtrOne = 1;

   typedef enum logic {StIdle, StLoad} state_e;

   state_e        r_state, w_state_d;
   logic [AW-1:0] r_ptr, w_ptr_d;
   logic [AW:0]   r_count, w_count_d;
   logic          r_done, w_done_d;
   logic          r_err, w_err_d;

   logic [DW-1:0] r_mem [Depth];

   logic          w_load;
   logic          w_bus_rd;
   logic          w_bus_wr;
   logic          w_ld_wr;
   logic          w_fault;
   logic          w_we;
   logic [AW-1:0] w_waddr;
   logic [DW-1:0] w_wdata;

   assign w_load   = (r_state == StLoad);
   // Bus accesses are served only in IDLE and never while reset is asserted.
   assign w_bus_rd = rst & ~w_load & bus.rd & ~bus.wrt;
   assign w_bus_wr = rst & ~w_load & bus.wrt & ~bus.rd;
   assign w_ld_wr  = w_load & bus.ld_valid;
   assign w_fault  = (bus.rd & bus.wrt) | (w_load & (bus.rd | bus.wrt));

   // Single write port: loader and bus writes are mutually exclusive by state,
   // the loader mux leg is listed first so it wins by construction.
   assign w_we    = w_ld_wr | w_bus_wr;
   assign w_waddr = w_ld_wr ? r_ptr : bus.add;
   assign w_wdata = w_ld_wr ? bus.ld_data : dat;

   assign dat = w_bus_rd ? r_mem[bus.add] : {DW{1'bz}};

   assign bus.ld_ready = w_load;
   assign bus.cpu_hold = w_load;
   assign bus.ld_done  = r_done;
   assign bus.ld_count = r_count;
   assign bus.bus_err  = r_err;

   // Next-state logic for the IDLE/LOAD controller, loader pointer and flags.
   always_comb begin
      w_state_d = r_state;
      w_ptr_d   = r_ptr;
      w_count_d = r_count;
      w_done_d  = 1'b0;
      w_err_d   = r_err | w_fault;
      unique case (r_state)
         StIdle: begin
            if (bus.ld_start) begin
               w_state_d = StLoad;
               w_ptr_d   = bus.ld_base;
               w_count_d = '0;
               w_err_d   = 1'b0;
            end
         end
         StLoad: begin
            if (bus.ld_valid) begin
               w_ptr_d = r_ptr + PtrOne;
               if (r_count != CountMax) begin
                  w_count_d = r_count + CountOne;
               end
               if (bus.ld_last) begin
                  w_state_d = StIdle;
                  w_done_d  = 1'b1;
               end
            end
         end
         default: w_state_d = StIdle;
      endcase
   end

   // Controller state with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= StIdle;
         r_ptr   <= '0;
         r_count <= '0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_d;
         r_ptr   <= w_ptr_d;
         r_count <= w_count_d;
         r_done  <= w_done_d;
         r_err   <= w_err_d;
      end
   end

   // Memory array: no reset so contents survive it and the array maps to RAM.
   always_ff @(posedge clk) begin
      if (w_we) begin
         r_mem[w_waddr] <= w_wdata;
      end
   end

endmodule

// File: doc/bus_memory.md
BUS_MEMORY -- requirements
Module: bus_memory

Interface
REQ-001 Parameter: AW, 8, address width; depth = 2^AW bytes.
REQ-002 Parameter: DW, 8, data width.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset; asynchronous, active-low.
REQ-005 Port: add  input  AW  processor bus address.
REQ-006 Port: rd  input  1  processor read strobe.
REQ-007 Port: wrt  input  1  processor write strobe.
REQ-008 Port: dat  inout  DW  shared processor data bus.
REQ-009 Port: ld_start  input  1  one-cycle pulse that begins a program load.
REQ-010 Port: ld_base  input  AW  first load address, sampled with ld_start.
REQ-011 Port: ld_valid  input  1  load byte valid.
REQ-012 Port: ld_data  input  DW  load byte.
REQ-013 Port: ld_last  input  1  marks the final load byte; qualified by ld_valid.
REQ-014 Port: ld_ready  output  1  load byte accepted this cycle when high with ld_valid.
REQ-015 Port: cpu_hold  output  1  processor must be held in reset while high.
REQ-016 Port: ld_done  output  1  one-cycle pulse after the last load byte is written.
REQ-017 Port: ld_count  output  AW+1  bytes written by the current or most recent load.
REQ-018 Port: bus_err  output  1  sticky bus-fault flag.

Function
REQ-019 The block SHALL have two states: IDLE (serve the processor bus) and LOAD (accept loader bytes).
REQ-020 IDLE -> LOAD SHALL occur on ld_start=1 at a clock edge; on that edge, ptr <= ld_base and ld_count <= 0.
REQ-021 LOAD -> IDLE SHALL occur on the edge where ld_valid=1 and ld_last=1; ld_done SHALL be 1 for the following cycle only.
REQ-022 ld_start SHALL be ignored while in LOAD.
REQ-023 ld_ready SHALL equal (state==LOAD), combinationally.
REQ-024 cpu_hold SHALL equal (state==LOAD), combinationally.
REQ-025 In LOAD, each edge with ld_valid=1 SHALL write mem[ptr] <= ld_data, increment ptr modulo 2^AW (0xFF wraps to 0x00), and increment ld_count.
REQ-026 ld_count SHALL saturate at 2^AW.
REQ-027 A load exceeding 2^AW bytes SHALL overwrite from the wrapped address.
REQ-028 Bus read, IDLE only: when rd=1 and wrt=0, dat SHALL be driven combinationally with mem[add] (zero-latency).
REQ-029 A bus read SHALL be stable before the edge that ends the rd cycle, because the processor samples dat one edge after asserting rd.
REQ-030 In all other cases, dat SHALL be high-impedance.
REQ-031 Bus write, IDLE only: on each edge with wrt=1 and rd=0, the block SHALL write mem[add] <= dat.
REQ-032 Each cycle with wrt=1 SHALL be one write; no edge detection SHALL be applied.
REQ-033 rd=1 and wrt=1 together SHALL cause no drive and no write, and SHALL set bus_err.
REQ-034 rd or wrt asserted while in LOAD SHALL be ignored (no drive, no write) and SHALL set bus_err.
REQ-035 bus_err SHALL clear only on reset or on ld_start acceptance.
REQ-036 When a loader write and a bus access target the same cycle, the loader SHALL win; this case can only occur in LOAD.
REQ-037 The memory array SHALL be inferable as single-write-port RAM with an asynchronous read.

Reset
REQ-038 rst=0 SHALL immediately force: state=IDLE, ptr=0, ld_count=0, ld_done=0, bus_err=0, ld_ready=0, cpu_hold=0, dat=Z.
REQ-039 Memory contents SHALL NOT be altered by reset.
REQ-040 Reset asserted mid-load SHALL abort the load; bytes already written SHALL remain, and no ld_done SHALL be issued.

Verification
REQ-041 Load check: ld_start with ld_base=0x10, then bytes 0xA1,0xA2,0xA3 with ld_last on 0xA3 -> mem[0x10..0x12]=A1,A2,A3; ld_done pulses once; ld_count=3; cpu_hold high exactly three cycles.
REQ-042 Wrap check: ld_base=0xFE, bytes 0x11,0x22,0x33 (ld_last on 0x33) -> mem[0xFE]=0x11, mem[0xFF]=0x22, mem[0x00]=0x33.
REQ-043 Bus round-trip check: in IDLE, wrt=1, add=0x40, dat=0x5C for one cycle; then rd=1, add=0x40 -> dat=0x5C in the same cycle; dat=Z when rd=0.
REQ-044 Fault check: rd=1 and wrt=1 at add=0x40 -> mem[0x40] unchanged, dat=Z, bus_err=1 until the next ld_start.
REQ-045 Reset-mid-load check: ld_base=0x20, two bytes 0x01,0x02, then rst=0 -> state IDLE, cpu_hold=0, no ld_done; mem[0x20]=0x01 and mem[0x21]=0x02 after reset release.
REQ-046 Processor integration check: load program {0x81 (lms 1), 0x00}, release cpu_hold, run the processor -> gr[7:4]=0x1 after one instruction, and no bus_err.
